seg7_scan_decoder: RTL

//  Receive side of the floor-indicator 7-segment link: the inverse of the hex->segment encoder.
//  - Snoops a time-multiplexed, active-low segment bus with active-low digit enables.
//  - Debounces each digit's pattern and decodes it back to a 4-bit hex value.
//  - Reports each change through a valid/ready handshake. Used by the floor/status monitor.

---
 rtl/seg7_scan_decoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, debounces and decodes each digit.
// Optional decimal-point tracking is enabled with SEG7_DP_EN.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3,
  parameter int IW         = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic [0:6]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
`ifdef SEG7_DP_EN
  input  logic                    seg_dp_in,
  output logic                    out_dp,
  output logic [NUM_DIGITS-1:0]   dp_flat,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IW-1:0]           out_idx,
  output logic [3:0]              out_digit,
  output logic                    out_bad,
  output logic [4*NUM_DIGITS-1:0] digits_flat,
  output logic [NUM_DIGITS-1:0]   digit_ok
);

`ifdef SEG7_DP_EN
  localparam int PW = 8;
`else
  localparam int PW = 7;
`endif
  localparam logic [3:0] SC = 4'(STABLE_CNT);

  typedef enum logic {IDLE, PEND} state_t;

  state_t state, state_nx;

  logic [PW-1:0] cand [NUM_DIGITS];
  logic [PW-1:0] comm [NUM_DIGITS];
  logic [3:0]    cnt  [NUM_DIGITS];

  logic [PW-1:0] pat;
  logic [IW-1:0] sel;
  logic [3:0]    zcnt;
  logic          take;
  logic [3:0]    cnt_nx;
  logic          commit;
  logic          blank;
  logic          hit;
  logic [3:0]    val;
  logic          ev;

`ifdef SEG7_DP_EN
  assign pat = {seg_dp_in, seg_in};
`else
  assign pat = seg_in;
`endif

  function automatic logic [4:0] dec(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0001100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  // A sample is usable only when exactly one digit enable is low
  always_comb begin
    zcnt = '0;
    sel  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!an_in[k]) begin
        zcnt = zcnt + 4'd1;
        sel  = IW'(k);
      end
    end
    take = sample_en && (zcnt == 4'd1);
  end

  always_comb begin
    cnt_nx = 4'd1;
    if (pat == cand[sel])
      cnt_nx = (cnt[sel] == SC) ? cnt[sel] : cnt[sel] + 4'd1;
    {hit, val} = dec(pat[6:0]);
    blank  = (pat[6:0] == 7'h7F);
    commit = take && (cnt_nx == SC) && (pat != comm[sel])
             && (!out_valid || out_ready);
    ev     = commit && !blank;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (ev) state_nx = PEND;
      PEND: if (out_ready) state_nx = ev ? PEND : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign out_valid = (state == PEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        cand[k] <= '1;
        comm[k] <= '1;
        cnt[k]  <= '0;
      end
      digits_flat <= '0;
      digit_ok    <= '0;
    end else if (take) begin
      cand[sel] <= pat;
      cnt[sel]  <= cnt_nx;
      if (commit) begin
        comm[sel]     <= pat;
        digit_ok[sel] <= hit;
        if (hit) digits_flat[4*sel +: 4] <= val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_idx   <= '0;
      out_digit <= '0;
      out_bad   <= 1'b0;
    end else if (ev) begin
      out_idx   <= sel;
      out_digit <= hit ? val : 4'd0;
      out_bad   <= !hit;
    end
  end

`ifdef SEG7_DP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_dp  <= 1'b0;
      dp_flat <= '0;
    end else begin
      if (ev) out_dp <= hit && !pat[7];
      if (commit && hit) dp_flat[sel] <= !pat[7];
    end
  end
`endif

endmodule
